// File: rtl/axi_rd_pkg.sv
// Shared encodings for the AXI read-data sink: burst and response codes,
// response severity ranking, status bit positions and FSM state codes.
package axi_rd_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } resp_e;

   localparam int ERR_EARLY_LAST = 0;
   localparam int ERR_NO_LAST    = 1;
   localparam int ERR_SIZE       = 2;
   localparam int ERR_BURST      = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Higher rank means a worse response.
   function automatic logic [1:0] resp_rank(input logic [1:0] resp);
      case (resp)
         RESP_DECERR: return 2'd3;
         RESP_SLVERR: return 2'd2;
         RESP_EXOKAY: return 2'd1;
         default:     return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/rd_sink_mem.sv
// One-write/one-read synchronous RAM with per-byte write enables.
// Readback is registered and returns the old word on a same-cycle collision.
module rd_sink_mem
   import axi_rd_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 16384
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [DATA_W/8-1:0]          be,
   input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]            rdata
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_rd_data_sink.sv
// AXI4 read-data channel sink: takes one burst descriptor, accepts R beats into
// a byte-enabled buffer at FIXED/INCR/WRAP addresses and reports burst status.
module axi_rd_data_sink
   import axi_rd_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 16,
   parameter int MEM_DEPTH = 16384
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_len,
   input  logic [2:0]        cmd_size,
   input  logic [1:0]        cmd_burst,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic              done,
   output logic [1:0]        done_resp,
   output logic [3:0]        done_err,
   output logic [7:0]        done_beats,
   input  logic [ADDR_W-1:0] mem_raddr,
   output logic [DATA_W-1:0] mem_rdata
);

   localparam int NB     = DATA_W / 8;
   localparam int NB_LOG = $clog2(NB);
   localparam int IDX_W  = $clog2(MEM_DEPTH);

   logic [1:0]        state;
   logic [ADDR_W-1:0] base_addr, cur_addr, next_addr;
   logic [7:0]        len_q, cnt;
   logic [2:0]        size_q;
   logic [1:0]        burst_q;
   logic              beat, last_beat, size_bad, burst_bad;
   logic [ADDR_W-1:0] bytes_b, total_t, wrap_lo, incr_addr;
   logic [ADDR_W:0]   step_x, wrap_hi_x;
   logic [NB-1:0]     be;
   logic [NB_LOG-1:0] lane_lo, lane;

   assign cmd_ready = (state == ST_IDLE);
   assign beat      = rready && rvalid;
   assign last_beat = rlast || (cnt == len_q);
   assign size_bad  = int'(size_q) > NB_LOG;
   assign burst_bad = (burst_q == BURST_RSVD) ||
                      ((burst_q == BURST_WRAP) && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}));

   // Next-beat address; the wrap compare is one bit wider so boundary+T cannot overflow.
   always_comb begin
      bytes_b   = ADDR_W'(1) << size_q;
      total_t   = bytes_b * (ADDR_W'(len_q) + ADDR_W'(1));
      wrap_lo   = base_addr & ~(total_t - ADDR_W'(1));
      wrap_hi_x = {1'b0, wrap_lo} + {1'b0, total_t};
      step_x    = {1'b0, cur_addr} + {1'b0, bytes_b};
      incr_addr = (cur_addr & ~(bytes_b - ADDR_W'(1))) + bytes_b;
      case (burst_q)
         BURST_INCR: next_addr = incr_addr;
         BURST_WRAP: next_addr = (step_x >= wrap_hi_x) ? wrap_lo : step_x[ADDR_W-1:0];
         default:    next_addr = base_addr;
      endcase
   end

   // Lanes from the beat's byte offset up to the next size-aligned boundary.
   always_comb begin
      lane_lo = cur_addr[NB_LOG-1:0];
      lane    = '0;
      be      = '0;
      for (int i = 0; i < NB; i++) begin
         lane  = NB_LOG'(i);
         be[i] = (lane >= lane_lo) && ((lane >> size_q) == (lane_lo >> size_q));
      end
   end

   always_ff @(posedge aclk) begin
      if (cmd_ready && cmd_valid) begin
         base_addr <= cmd_addr;
         cur_addr  <= cmd_addr;
         len_q     <= cmd_len;
         size_q    <= cmd_size;
         burst_q   <= cmd_burst;
         cnt       <= 8'd0;
      end else if (beat) begin
         cur_addr <= next_addr;
         cnt      <= cnt + 8'd1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state      <= ST_IDLE;
         rready     <= 1'b0;
         done       <= 1'b0;
         done_resp  <= 2'd0;
         done_err   <= 4'd0;
         done_beats <= 8'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  done_resp  <= 2'd0;
                  done_err   <= 4'd0;
                  done_beats <= 8'd0;
                  state      <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (size_bad || burst_bad) begin
                  done_err[ERR_SIZE]  <= size_bad;
                  done_err[ERR_BURST] <= burst_bad;
                  done                <= 1'b1;
                  state               <= ST_DONE;
               end else begin
                  rready <= 1'b1;
                  state  <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (beat) begin
                  done_beats <= cnt + 8'd1;
                  if (resp_rank(rresp) > resp_rank(done_resp)) done_resp <= rresp;
                  if (last_beat) begin
                     done_err[ERR_EARLY_LAST] <= rlast && (cnt != len_q);
                     done_err[ERR_NO_LAST]    <= !rlast && (cnt == len_q);
                     rready                   <= 1'b0;
                     done                     <= 1'b1;
                     state                    <= ST_DONE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   rd_sink_mem #(
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk   (aclk),
      .we    (beat && !areset),
      .be    (be),
      .waddr (IDX_W'(cur_addr >> NB_LOG)),
      .wdata (rdata),
      .raddr (IDX_W'(mem_raddr >> NB_LOG)),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_axi_rd_data_sink.sv
// Randomised bench for axi_rd_data_sink against a byte-level reference model
// of the buffer and the burst status rules.
module tb_axi_rd_data_sink;

   logic        aclk = 1'b0;
   logic        areset, cmd_valid, cmd_ready;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic [1:0]  cmd_burst;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready, done;
   logic [1:0]  done_resp;
   logic [3:0]  done_err;
   logic [7:0]  done_beats;
   logic [15:0] mem_raddr;
   logic [31:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  ref_mem [65536];
   bit          known   [65536];
   logic [31:0] bd [256];
   logic [1:0]  br [256];
   int          last_idx, gap_pct, reset_at;
   logic [15:0] words [$];

   always #5 aclk = ~aclk;

   axi_rd_data_sink #(.DATA_W(32), .ADDR_W(16), .MEM_DEPTH(16384)) dut (
      .aclk(aclk), .areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .done(done), .done_resp(done_resp), .done_err(done_err), .done_beats(done_beats),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] beat_addr(input logic [15:0] s, input int len,
                                             input int size, input int burst, input int k);
      int b, t, bound;
      b = 1 << size;
      t = b * (len + 1);
      if (burst == 0) return s;
      if (burst == 1) return (k == 0) ? s : 16'((int'(s) & ~(b - 1)) + k * b);
      bound = int'(s) & ~(t - 1);
      return 16'(bound + ((int'(s) - bound + k * b) % t));
   endfunction

   task automatic model_beat(input logic [15:0] a, input int size, input logic [31:0] d);
      int lastb;
      lastb = int'(a) | ((1 << size) - 1);
      for (int x = int'(a); x <= lastb; x++) begin
         ref_mem[x] = d[8*(x % 4) +: 8];
         known[x]   = 1'b1;
      end
   endtask

   task automatic exp_word(input logic [15:0] a, output logic [31:0] w, output logic [31:0] m);
      logic [15:0] base;
      base = {a[15:2], 2'b00};
      w = '0;
      m = '0;
      for (int l = 0; l < 4; l++) begin
         if (known[base + 16'(l)]) begin
            w[8*l +: 8] = ref_mem[base + 16'(l)];
            m[8*l +: 8] = 8'hFF;
         end
      end
   endtask

   task automatic readback(input logic [15:0] a);
      logic [31:0] w, m;
      mem_raddr = a;
      @(posedge aclk); #1;
      exp_word(a, w, m);
      chk($sformatf("readback@%04h", a), mem_rdata & m, w & m);
   endtask

   task automatic readback_const(input string tag, input logic [15:0] a, input logic [31:0] w);
      mem_raddr = a;
      @(posedge aclk); #1;
      chk(tag, mem_rdata, w);
   endtask

   task automatic run_burst(input logic [15:0] addr, input int len, input int size, input int burst);
      int          k, cyc;
      bit          legal, ended, acc;
      logic [3:0]  eerr;
      logic [1:0]  eresp;
      logic [15:0] a;
      logic [31:0] ow, om;
      eerr = '0;
      if (size > 2) eerr[2] = 1'b1;
      if (burst == 3 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)))
         eerr[3] = 1'b1;
      legal = (eerr == 4'd0);
      words.delete();
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 8'(len);
      cmd_size = 3'(size); cmd_burst = 2'(burst);
      @(posedge aclk); #1;
      cmd_valid = 1'b0;
      rvalid = 1'b1; rdata = bd[0]; rresp = br[0]; rlast = (last_idx == 0);
      chk("check_rready", rready, 0);
      chk("check_cmd_ready", cmd_ready, 0);
      chk("cleared_beats", done_beats, 0);
      chk("cleared_err", done_err, 0);
      chk("cleared_resp", done_resp, 0);
      @(posedge aclk); #1;
      if (!legal) begin
         chk("ill_done", done, 1);
         chk("ill_err", done_err, eerr);
         chk("ill_beats", done_beats, 0);
         chk("ill_rready", rready, 0);
         @(posedge aclk); #1;
         chk("ill_done_pulse", done, 0);
         chk("ill_rready2", rready, 0);
         chk("ill_idle", cmd_ready, 1);
         rvalid = 1'b0; rlast = 1'b0;
         return;
      end
      chk("burst_rready", rready, 1);
      k = 0; cyc = 0; ended = 0; eresp = 2'd0;
      while (!ended && cyc < 400) begin
         a = beat_addr(addr, len, size, burst, k);
         rvalid = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
         rdata = bd[k]; rresp = br[k]; rlast = (k == last_idx); mem_raddr = a;
         if (k == reset_at) begin
            rvalid = 1'b1;
            areset = 1'b1;
         end
         acc = rvalid && rready;
         exp_word(a, ow, om);
         @(posedge aclk); #1;
         cyc++;
         if (k == reset_at) begin
            areset = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            chk("rst_rready", rready, 0);
            chk("rst_idle", cmd_ready, 1);
            chk("rst_done", done, 0);
            chk("rst_beats", done_beats, 0);
            chk("rst_err", done_err, 0);
            chk("rst_resp", done_resp, 0);
            return;
         end
         if (acc) begin
            if (om != 0) chk("rd_old_data", mem_rdata & om, ow & om);
            model_beat(a, size, bd[k]);
            words.push_back(a);
            if (br[k] > eresp) eresp = br[k];
            ended = (k == last_idx) || (k == len);
            k++;
         end
      end
      if (!ended) begin
         chk("burst_timeout", 0, 1);
         rvalid = 1'b0;
         return;
      end
      if (gap_pct == 0) chk("throughput", cyc, k);
      eerr[0] = (last_idx < len);
      eerr[1] = (last_idx > len);
      chk("done", done, 1);
      chk("done_rready", rready, 0);
      chk("done_beats", done_beats, k);
      chk("done_err", done_err, eerr);
      chk("done_resp", done_resp, eresp);
      rvalid = 1'b1; rlast = 1'b0; rdata = 32'hDEADBEEF;
      @(posedge aclk); #1;
      chk("done_pulse", done, 0);
      chk("back_idle", cmd_ready, 1);
      chk("hold_beats", done_beats, k);
      chk("stray_rready", rready, 0);
      rvalid = 1'b0;
      foreach (words[i]) readback(words[i]);
   endtask

   task automatic set_beats(input logic [31:0] base, input int li);
      for (int i = 0; i < 256; i++) begin
         bd[i] = base + 32'(i);
         br[i] = 2'd0;
      end
      last_idx = li; gap_pct = 0; reset_at = -1;
   endtask

   initial begin
      int burst, size, len, r;
      logic [15:0] addr;
      areset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
      cmd_burst = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0; mem_raddr = '0;
      repeat (3) @(posedge aclk);
      #1;
      chk("reset_rready", rready, 0);
      chk("reset_done", done, 0);
      chk("reset_resp", done_resp, 0);
      chk("reset_err", done_err, 0);
      chk("reset_beats", done_beats, 0);
      chk("reset_cmd_ready", cmd_ready, 1);
      areset = 1'b0;

      set_beats(32'h000000A0, 3);
      run_burst(16'h0100, 3, 2, 1);
      readback_const("incr_w40", 16'h0100, 32'h000000A0);
      readback_const("incr_w43", 16'h010C, 32'h000000A3);

      set_beats(32'h000000B0, 3);
      run_burst(16'h0108, 3, 2, 2);
      readback_const("wrap_100", 16'h0100, 32'h000000B2);
      readback_const("wrap_104", 16'h0104, 32'h000000B3);
      readback_const("wrap_108", 16'h0108, 32'h000000B0);
      readback_const("wrap_10C", 16'h010C, 32'h000000B1);

      set_beats(32'h000000C0, 1);
      run_burst(16'h0100, 3, 2, 1);
      readback_const("early_kept", 16'h0108, 32'h000000B0);

      set_beats(32'h000000E0, 3);
      br[1] = 2'd2; br[3] = 2'd3;
      run_burst(16'h0200, 3, 2, 1);

      set_beats(32'h11223344, 1);
      bd[1] = 32'h55667788;
      run_burst(16'h0000, 1, 2, 1);
      set_beats(32'hDDCCBBAA, 1);
      bd[1] = 32'h000000EE;
      run_burst(16'h0003, 1, 0, 1);
      readback_const("narrow_w0", 16'h0000, 32'hDD223344);
      readback_const("narrow_w1", 16'h0004, 32'h556677EE);

      set_beats(32'h0, 2);
      run_burst(16'h0300, 2, 2, 2);
      run_burst(16'h0300, 1, 3, 1);

      set_beats(32'h0C000000, 7);
      run_burst(16'h0800, 7, 2, 1);
      set_beats(32'h0D000000, 7);
      gap_pct = 40; reset_at = 2;
      run_burst(16'h0800, 7, 2, 1);
      set_beats(32'h0F000000, 0);
      run_burst(16'h0900, 0, 2, 1);
      for (int i = 0; i < 8; i++) readback(16'h0800 + 16'(4 * i));
      readback_const("rst_kept", 16'h0808, 32'h0C000002);

      for (int t = 0; t < 40; t++) begin
         r = int'($urandom_range(19));
         burst = (r == 0) ? 3 : (r % 3);
         size = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
         if (burst == 2)
            len = ($urandom_range(7) == 0) ? int'($urandom_range(15)) : ((2 << $urandom_range(3)) - 1);
         else
            len = int'($urandom_range(15));
         addr = 16'($urandom);
         if (burst == 2) addr = addr & ~16'((1 << size) - 1);
         for (int i = 0; i < 256; i++) begin
            bd[i] = $urandom;
            br[i] = 2'($urandom_range(3));
         end
         gap_pct = int'($urandom_range(3)) * 20;
         reset_at = -1;
         r = int'($urandom_range(9));
         if (r == 0)      last_idx = int'($urandom_range(len));
         else if (r == 1) last_idx = 300;
         else             last_idx = len;
         run_burst(addr, len, size, burst);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_rd_data_sink.md
# axi_rd_data_sink

Parametrised AXI4 read-data-channel receiver for the master side. It accepts one burst descriptor per command handshake and drives `rready`. Each accepted R beat is written into a local byte-enabled buffer at the FIXED, INCR or WRAP address, including narrow and unaligned beats. When the burst ends it reports a status word covering response errors and `rlast` protocol violations.

## Interface
- `DATA_W`, 32: R data width in bits; 32, 64 or 128.
- `ADDR_W`, 16: byte-address width.
- `MEM_DEPTH`, 16384: buffer depth in `DATA_W` words; power of 2.
- `aclk` in 1: the only clock; everything is on its rising edge.
- `areset` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: burst descriptor valid.
- `cmd_ready` out 1: descriptor accepted when high together with `cmd_valid`.
- `cmd_addr` in ADDR_W: start byte address.
- `cmd_len` in 8: AXI len; beats = len+1.
- `cmd_size` in 3: AXI size; bytes per beat = 1<<size.
- `cmd_burst` in 2: 0 FIXED, 1 INCR, 2 WRAP.
- `rdata` in DATA_W: read data.
- `rresp` in 2: read response.
- `rlast` in 1: last beat of the burst.
- `rvalid` in 1: R beat valid.
- `rready` out 1: ready to accept an R beat.
- `done` out 1: one-cycle pulse at burst end.
- `done_resp` out 2: worst response seen in the burst.
- `done_err` out 4: bit0 early `rlast`, bit1 missing `rlast`, bit2 illegal size, bit3 illegal WRAP len or burst value.
- `done_beats` out 8: number of beats accepted.
- `mem_raddr` in ADDR_W: readback byte address.
- `mem_rdata` out DATA_W: readback word, 1-cycle latency.

## Operation
- States and transitions:
  - IDLE: `cmd_ready`=1; a handshake latches the descriptor, then goes to CHECK.
  - CHECK: validates the descriptor. A legal descriptor goes to BURST. An illegal one goes to DONE with 0 beats; `rready` never rises.
  - BURST: `rready`=1. A beat is accepted when `rvalid`&&`rready`.
  - DONE: `done`=1 for this cycle only, then IDLE.
- Illegal descriptors:
  - size > log2(DATA_W/8).
  - WRAP with len not in {1,3,7,15}.
  - burst value 3.
- Per beat:
  - Word index = addr >> log2(DATA_W/8), modulo `MEM_DEPTH`.
  - Byte enables cover lanes from `addr` mod (DATA_W/8) up to the next (1<<size)-aligned boundary. Lanes outside this range are not written.
- Next-address rules:
  - FIXED: the address stays at `cmd_addr`.
  - INCR: next = (addr & ~(B-1)) + B, where B = 1<<size. Width is ADDR_W and the result wraps modulo 2^ADDR_W.
  - WRAP: total T = (len+1)*B; boundary = `cmd_addr` & ~(T-1). Next = addr+B, but if that is ≥ boundary+T, next = boundary.
- Beat counter `cnt` (8 bits) counts 0..len.
- `rlast` handling:
  - `rlast` with cnt<len: set err bit0 and end the burst after this beat.
  - cnt==len without `rlast`: set err bit1 and end the burst anyway.
  - Beats arriving after the burst ends are not accepted.
- `done_resp` is sticky within a burst: DECERR > SLVERR > EXOKAY > OKAY. It is cleared when a descriptor is accepted.
- Reset mid-burst: at the next edge the state is IDLE and `rready`=0. Buffer contents are kept.
- Reset values: `rready` 0, `done` 0, `done_resp` 0, `done_err` 0, `done_beats` 0, state IDLE so `cmd_ready`=1. `done_*` hold their values until the next descriptor is accepted.

## Timing
- Command handshake at edge N: CHECK during N+1, `rready`=1 from N+2.
- Full throughput: one beat per cycle while `rvalid` is held high.
- Final beat accepted at edge M: `rready`=0 and `done`=1 during M+1; `cmd_ready`=1 at M+2.
- Minimum burst period is len+4 cycles.
- Buffer write commits at the accepting edge.
- Readback is registered. A same-cycle write and read of the same word returns the old data.
- `cmd_ready` is a combinational decode of state. `rready`, `done` and `done_*` are registered.

## Structure
- Package `axi_rd_pkg` holds:
  - burst codes FIXED/INCR/WRAP;
  - response codes OKAY/EXOKAY/SLVERR/DECERR and the severity-rank function;
  - `done_err` bit indices;
  - state encoding.
- Sub-module `rd_sink_mem`: one-write/one-read synchronous RAM, `MEM_DEPTH` × `DATA_W`, with per-byte write enables. It is instantiated once.
- Address generation and byte-enable decode sit in the top level as combinational logic.

## Test plan
- INCR, addr 0x0100, len 3, size 2, data 0xA0..0xA3, `rvalid` held high → words 0x40..0x43 written; `done` exactly 4 cycles after the first beat; `done_beats`=4; `done_resp`=0; `done_err`=0.
- WRAP, addr 0x0108, len 3, size 2 → beat addresses 0x108, 0x10C, 0x100, 0x104; readback confirms each.
- Narrow, unaligned INCR, addr 0x0003, len 1, size 0, DATA_W=32 → beat 0 writes only lane 3 of word 0; beat 1 writes only lane 0 of word 1; other bytes unchanged.
- `rlast` on beat 1 of a len-3 burst → `rready` low after 2 beats; `done_err`=0001; `done_beats`=2.
- `rresp` sequence OKAY, SLVERR, OKAY, DECERR → `done_resp`=3.
- Illegal descriptors:
  - WRAP len 2 → `done` with `done_err`=1000, no `rready`.
  - size 3 with DATA_W=32 → `done_err`=0100.
- `areset` during beat 2 of 8, with random `rvalid` gaps throughout → `rready`=0 at the next edge; no further writes; a new command is accepted immediately afterwards.
